// File: rtl/prog_seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector family.
package prog_seq_det_pkg;

  localparam int DEF_MAX_W = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  // Width needed to hold a length value from 0 up to max_w inclusive.
  function automatic int len_width(input int max_w);
    return $clog2(max_w + 1);
  endfunction

endpackage

// File: rtl/prog_seq_det_cmp.sv
// Masked, length-limited pattern comparator: hit when every cared-for bit below len agrees.
module prog_seq_det_cmp
  import prog_seq_det_pkg::*;
#(
  parameter int MAX_W = DEF_MAX_W,
  parameter int LEN_W = len_width(MAX_W)
) (
  input  logic [MAX_W-1:0] hist,
  input  logic [MAX_W-1:0] seq,
  input  logic [MAX_W-1:0] mask,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < int'(len)) && mask[i] && (hist[i] != seq[i])) begin
        hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_seq_det.sv
// Runtime-programmable serial sequence detector with fill guard and saturating match counter.
// Optional macro PROG_SEQ_DET_CLR_EN adds a cnt_clr input that zeroes the counter in place.
module prog_seq_det
  import prog_seq_det_pkg::*;
#(
  parameter int MAX_W = DEF_MAX_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = len_width(MAX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_seq,
  input  logic [MAX_W-1:0] cfg_mask,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
`ifdef PROG_SEQ_DET_CLR_EN
  input  logic             cnt_clr,
`endif
  output logic             armed,
  output logic             out_match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  state_t           state;
  // The oldest history bit would never reach the comparator, so only MAX_W-1 bits are kept.
  logic [MAX_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] len_r;
  logic [MAX_W-1:0] seq_r;
  logic [MAX_W-1:0] mask_r;
  logic             overlap_r;

  logic [MAX_W-1:0] hist_n;
  logic [LEN_W-1:0] fill_n;
  logic [LEN_W-1:0] len_clamp;
  logic             accept;
  logic             full;
  logic             hit;
  logic             match;
  logic             clr;

`ifdef PROG_SEQ_DET_CLR_EN
  assign clr = cnt_clr;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    len_clamp = (cfg_len > LEN_W'(MAX_W)) ? LEN_W'(MAX_W) : cfg_len;
    accept    = in_valid && !cfg_load && (state != IDLE);
    hist_n    = {hist, in_bit};
    fill_n    = (fill < len_r) ? fill + LEN_W'(1) : fill;
    full      = (fill_n == len_r);
    match     = accept && full && hit;
  end

  prog_seq_det_cmp #(
    .MAX_W (MAX_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist (hist_n),
    .seq  (seq_r),
    .mask (mask_r),
    .len  (len_r),
    .hit  (hit)
  );

  assign armed = (state == ARMED);

  // A non-overlapping match restarts the fill guard so a fresh full pattern is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      len_r     <= '0;
      seq_r     <= '0;
      mask_r    <= '0;
      overlap_r <= 1'b0;
      out_match <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (cfg_load) begin
      seq_r     <= cfg_seq;
      mask_r    <= cfg_mask;
      overlap_r <= cfg_overlap;
      len_r     <= len_clamp;
      hist      <= '0;
      fill      <= '0;
      out_match <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      state     <= (len_clamp == '0) ? IDLE : FILL;
    end else begin
      out_match <= match;
      if (accept) begin
        hist <= hist_n[MAX_W-2:0];
        if (match && !overlap_r) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill  <= fill_n;
          state <= full ? ARMED : FILL;
        end
      end
      if (clr) begin
        match_cnt <= match ? CNT_W'(1) : '0;
        cnt_sat   <= 1'b0;
      end else if (match) begin
        if (&match_cnt) begin
          cnt_sat <= 1'b1;
        end else begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_seq_det.sv
// Self-checking bench for prog_seq_det: directed tables, corner sequences and a random run vs a window model.
// Two instances share stimulus: default counter width, and a 2-bit counter for saturation.
module tb_prog_seq_det;

  localparam int MW = 16;
  localparam int LW = 5;

  typedef struct {
    bit v;
    bit b;
    bit em;
    int ecnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [MW-1:0] cfg_seq, cfg_mask;
  logic [LW-1:0] cfg_len;
  logic          armed_a, match_a, sat_a;
  logic [7:0]    cnt_a;
  logic          armed_b, match_b, sat_b;
  logic [1:0]    cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model: window of accepted bits since the last config / non-overlapping match.
  int            m_len;
  logic [MW-1:0] m_seq, m_mask;
  bit            m_ovl;
  bit            q[$];
  int            m_cnt;
  bit            m_match;
  vec_t          tbl[$];

  always #5 clk = ~clk;

  prog_seq_det dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_seq(cfg_seq), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef PROG_SEQ_DET_CLR_EN
    .cnt_clr(cnt_clr),
`endif
    .armed(armed_a), .out_match(match_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  prog_seq_det #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_seq(cfg_seq), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef PROG_SEQ_DET_CLR_EN
    .cnt_clr(cnt_clr),
`endif
    .armed(armed_b), .out_match(match_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int capped(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Advances the model by one edge using the inputs that were present at that edge.
  task automatic modelEdge();
    if (rst) begin
      m_len = 0; m_seq = '0; m_mask = '0; m_ovl = 0;
      q.delete(); m_cnt = 0; m_match = 0;
    end else if (cfg_load) begin
      m_len  = (int'(cfg_len) > MW) ? MW : int'(cfg_len);
      m_seq  = cfg_seq;
      m_mask = cfg_mask;
      m_ovl  = cfg_overlap;
      q.delete(); m_cnt = 0; m_match = 0;
    end else begin
      m_match = 0;
      if (in_valid && m_len > 0) begin
        q.push_back(in_bit);
        if (q.size() > m_len) void'(q.pop_front());
        if (q.size() == m_len) begin
          bit hitm = 1;
          for (int k = 0; k < m_len; k++)
            if (m_mask[k] && (q[m_len-1-k] != m_seq[k])) hitm = 0;
          if (hitm) begin
            m_match = 1;
            m_cnt++;
            if (!m_ovl) q.delete();
          end
        end
      end
      if (cnt_clr) m_cnt = m_match ? 1 : 0;
    end
  endtask

  task automatic checkOutput();
    bit exp_armed;
    exp_armed = (m_len > 0) && (q.size() == m_len);
    chk("match_a", match_a, m_match);
    chk("armed_a", armed_a, exp_armed);
    chk("cnt_a",   cnt_a,   capped(m_cnt, 255));
    chk("sat_a",   sat_a,   m_cnt > 255);
    chk("match_b", match_b, m_match);
    chk("armed_b", armed_b, exp_armed);
    chk("cnt_b",   cnt_b,   capped(m_cnt, 3));
    chk("sat_b",   sat_b,   m_cnt > 3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput();
  endtask

  task automatic applyStimulus(input bit v, input bit b);
    in_valid = v; in_bit = b; cfg_load = 0; cnt_clr = 0; rst = 0;
    tick();
    in_valid = 0;
  endtask

  task automatic loadCfg(input logic [MW-1:0] s, input logic [MW-1:0] m,
                         input int len, input bit ovl);
    cfg_seq = s; cfg_mask = m; cfg_len = LW'(len); cfg_overlap = ovl;
    cfg_load = 1; in_valid = 0; cnt_clr = 0; rst = 0;
    tick();
    cfg_load = 0;
  endtask

  task automatic addv(input bit v, input bit b, input bit em, input int ec);
    vec_t t;
    t.v = v; t.b = b; t.em = em; t.ecnt = ec;
    tbl.push_back(t);
  endtask

  task automatic runTable(input string name);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].b);
      chk({name, "_match"}, match_a, tbl[i].em);
      chk({name, "_cnt"}, cnt_a, tbl[i].ecnt);
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_bit = 0; cfg_load = 0; cnt_clr = 0;
    cfg_seq = '0; cfg_mask = '0; cfg_len = '0; cfg_overlap = 0;
    tick(); tick();
    rst = 0;
    chk("rst_match", match_a, 0);
    chk("rst_armed", armed_a, 0);
    chk("rst_cnt",   cnt_a,   0);
    chk("rst_sat",   sat_a,   0);
    applyStimulus(1, 1);
    chk("idle_ignores", match_a, 0);

    // Overlapping detection of 10010, with one ignored invalid cycle.
    loadCfg(16'b10010, 16'hFFFF, 5, 1);
    addv(1,1,0,0); addv(1,0,0,0); addv(1,0,0,0); addv(1,1,0,0);
    addv(1,0,1,1); addv(1,1,0,1); addv(1,1,0,1); addv(0,1,0,1);
    addv(1,1,0,1); addv(1,0,0,1); addv(1,0,0,1); addv(1,1,0,1);
    addv(1,0,1,2); addv(1,0,0,2); addv(1,1,0,2); addv(1,0,1,3);
    runTable("ovl");

    // Non-overlapping: trailing 0,1,0 must not re-trigger.
    loadCfg(16'b10010, 16'hFFFF, 5, 0);
    addv(1,1,0,0); addv(1,0,0,0); addv(1,0,0,0); addv(1,1,0,0);
    addv(1,0,1,1); addv(1,0,0,1); addv(1,1,0,1); addv(1,0,0,1);
    runTable("novl");

    // Mask 1011 makes the second received bit a don't-care.
    loadCfg(16'b1001, 16'b1011, 4, 0);
    addv(1,1,0,0); addv(1,1,0,0); addv(1,0,0,0); addv(1,1,1,1);
    runTable("mask1101");
    loadCfg(16'b1001, 16'b1011, 4, 0);
    addv(1,1,0,0); addv(1,0,0,0); addv(1,0,0,0); addv(1,1,1,1);
    runTable("mask1001");
    loadCfg(16'b1001, 16'b1011, 4, 0);
    addv(1,0,0,0); addv(1,1,0,0); addv(1,0,0,0); addv(1,1,0,0);
    runTable("mask0101");

    // Fill guard with idle gaps between accepted zeros.
    loadCfg(16'b000, 16'hFFFF, 3, 1);
    applyStimulus(1, 0); chk("fill1_match", match_a, 0); chk("fill1_armed", armed_a, 0);
    applyStimulus(0, 0); applyStimulus(0, 1);
    applyStimulus(1, 0); chk("fill2_match", match_a, 0); chk("fill2_armed", armed_a, 0);
    applyStimulus(0, 1); chk("gap_match", match_a, 0);
    applyStimulus(1, 0); chk("fill3_match", match_a, 1); chk("fill3_armed", armed_a, 1);
    applyStimulus(0, 0); chk("after_gap_match", match_a, 0); chk("after_gap_cnt", cnt_a, 1);

    // Reload mid-pattern discards collected history.
    loadCfg(16'b10010, 16'hFFFF, 5, 1);
    applyStimulus(1, 1); applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(1, 1);
    loadCfg(16'b10010, 16'hFFFF, 5, 1);
    applyStimulus(1, 0);
    chk("reload_match", match_a, 0);
    chk("reload_cnt",   cnt_a,   0);
    chk("reload_armed", armed_a, 0);

    // cfg_load with an in_valid bit in the same cycle drops the bit.
    cfg_seq = 16'b1; cfg_mask = 16'h1; cfg_len = 5'd1; cfg_overlap = 1;
    cfg_load = 1; in_valid = 1; in_bit = 1;
    tick();
    cfg_load = 0; in_valid = 0;
    chk("load_drop_match", match_a, 0);
    chk("load_drop_armed", armed_a, 0);

    // Oversized length clamps to MAX_W.
    loadCfg(16'h0000, 16'h0000, 31, 1);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0);
    chk("clamp_not_yet", armed_a, 0);
    applyStimulus(1, 1);
    chk("clamp_match", match_a, 1);

    // Saturation on the 2-bit counter instance.
    loadCfg(16'h0, 16'h0, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, k[0]);
      chk("sat_match", match_b, 1);
      chk("sat_cnt_b", cnt_b, (k > 3) ? 3 : k);
      chk("sat_flag_b", sat_b, k >= 4);
      chk("sat_cnt_a", cnt_a, k);
    end
`ifdef PROG_SEQ_DET_CLR_EN
    cnt_clr = 1; in_valid = 0;
    tick();
    cnt_clr = 0;
    chk("clr_cnt_b", cnt_b, 0);
    chk("clr_sat_b", sat_b, 0);
    chk("clr_armed", armed_a, 1);
    cnt_clr = 1; in_valid = 1; in_bit = 0;
    tick();
    cnt_clr = 0; in_valid = 0;
    chk("clr_match_cnt", cnt_a, 1);
`endif

    // Randomized run against the window model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      rst = (r == 0);
      cfg_load = (r >= 1 && r < 4);
      if (cfg_load) begin
        cfg_len     = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 31))
                                                   : LW'($urandom_range(0, 5));
        cfg_seq     = MW'($urandom);
        cfg_mask    = ($urandom_range(0, 1) == 0) ? '1 : MW'($urandom);
        cfg_overlap = $urandom_range(0, 1);
      end
      in_valid = ($urandom_range(0, 9) < 7);
      in_bit   = $urandom_range(0, 1);
`ifdef PROG_SEQ_DET_CLR_EN
      cnt_clr  = ($urandom_range(0, 49) == 0);
`else
      cnt_clr  = 0;
`endif
      tick();
    end
    rst = 0; cfg_load = 0; in_valid = 0; cnt_clr = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
